// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int unsigned LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// Multi-flop synchroniser for a single asynchronous level; data flops carry no reset.
module pll_seq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification sequencer on refclk.
// Optional PLLSEQ_SOFT_RESET_EN adds soft_rst_req to restart the PLL from any non-FAIL state.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 742500,
  parameter int unsigned STABLE_CYCLES  = 7425,
  parameter int unsigned MAX_RETRIES    = 4,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
`ifdef PLLSEQ_SOFT_RESET_EN
  input  logic                  soft_rst_req,
`endif
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  lock_fail,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int unsigned CNT_W =
    $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRIES - 1);

  pll_seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [RTY_W-1:0]      retry_q, retry_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  pll_rst_q, pll_rst_d;
  logic                  sys_rst_q, sys_rst_d;
  logic                  ready_q, ready_d;
  logic                  lock_fail_q, lock_fail_d;
  logic                  lk;

  pll_seq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(refclk),
    .d_i  (pll_locked),
    .q_o  (lk)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= PLL_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      PLL_RST: begin
        if (timer_q == PRST_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          timer_d = '0;
          if (retry_q == RTY_LAST) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = PLL_RST;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      STABLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STB_LAST) begin
          state_d = RUN;
          timer_d = '0;
          retry_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          if (loss_q != '1) begin
            loss_d = loss_q + LOSS_CNT_W'(1);
          end
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = PLL_RST;
        timer_d = '0;
      end
    endcase
`ifdef PLLSEQ_SOFT_RESET_EN
    if (soft_rst_req && (state_q != FAIL)) begin
      state_d = PLL_RST;
      timer_d = '0;
      retry_d = '0;
      loss_d  = loss_q;
    end
`endif
  end

  // Outputs are decoded from the current state and registered, so they trail state by one edge.
  always_comb begin
    pll_rst_d   = (state_q == PLL_RST);
    sys_rst_d   = (state_q != RUN);
    ready_d     = (state_q == RUN);
    lock_fail_d = (state_q == FAIL);
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign lock_fail       = lock_fail_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised and directed bench for pll_reset_sequencer against a duration-based reference model.
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LTO = 100;
  localparam int STC = 10;
  localparam int MR  = 2;
  localparam int SS  = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_QUAL = 2;
  localparam int P_RUN  = 3;
  localparam int P_DEAD = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
`ifdef PLLSEQ_SOFT_RESET_EN
  logic       soft_rst_req = 1'b0;
`endif
  logic       pll_rst, sys_rst, ready, lock_fail;
  logic [7:0] lock_loss_count;

  int n_pass = 0;
  int n_total = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LTO),
    .STABLE_CYCLES (STC),
    .MAX_RETRIES   (MR),
    .SYNC_STAGES   (SS)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
`ifdef PLLSEQ_SOFT_RESET_EN
    .soft_rst_req   (soft_rst_req),
`endif
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .lock_fail      (lock_fail),
    .lock_loss_count(lock_loss_count)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: phase plus time spent in it; lock seen SS edges after pll_locked is sampled.
  logic lk_pipe[$];
  int   m_phase, m_age, m_tries, m_loss;
  int   e_pll_rst, e_sys_rst, e_ready, e_fail;
  bit   m_valid = 1'b0;
  logic m_lk;
  bit   soft_hit;

  initial for (int i = 0; i < SS; i++) lk_pipe.push_back(1'b0);

  always @(posedge refclk) begin
    m_lk = lk_pipe.pop_front();
    lk_pipe.push_back(pll_locked);
    soft_hit = 1'b0;
`ifdef PLLSEQ_SOFT_RESET_EN
    soft_hit = soft_rst_req && (m_phase != P_DEAD);
`endif
    if (rst) begin
      m_phase = P_RST; m_age = 0; m_tries = 0; m_loss = 0;
      e_pll_rst = 1; e_sys_rst = 1; e_ready = 0; e_fail = 0;
      m_valid = 1'b1;
    end else begin
      e_pll_rst = (m_phase == P_RST)  ? 1 : 0;
      e_sys_rst = (m_phase == P_RUN)  ? 0 : 1;
      e_ready   = (m_phase == P_RUN)  ? 1 : 0;
      e_fail    = (m_phase == P_DEAD) ? 1 : 0;
      if (soft_hit) begin
        m_phase = P_RST; m_age = 0; m_tries = 0;
      end else begin
        case (m_phase)
          P_RST: begin
            m_age++;
            if (m_age == PRC) begin m_phase = P_WAIT; m_age = 0; end
          end
          P_WAIT: begin
            if (m_lk) begin
              m_phase = P_QUAL; m_age = 0;
            end else begin
              m_age++;
              if (m_age == LTO) begin
                m_age = 0;
                if (m_tries + 1 == MR) m_phase = P_DEAD;
                else begin m_tries++; m_phase = P_RST; end
              end
            end
          end
          P_QUAL: begin
            if (!m_lk) begin
              m_phase = P_WAIT; m_age = 0;
            end else begin
              m_age++;
              if (m_age == STC) begin m_phase = P_RUN; m_age = 0; m_tries = 0; end
            end
          end
          P_RUN: begin
            if (!m_lk) begin
              m_phase = P_WAIT; m_age = 0;
              if (m_loss < 255) m_loss++;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge refclk) begin
    if (m_valid) begin
      check("pll_rst",   int'(pll_rst),         e_pll_rst);
      check("sys_rst",   int'(sys_rst),         e_sys_rst);
      check("ready",     int'(ready),           e_ready);
      check("lock_fail", int'(lock_fail),       e_fail);
      check("loss_cnt",  int'(lock_loss_count), m_loss);
    end
  end

  task automatic reset_for(input int n);
    @(negedge refclk);
    rst = 1'b1;
    repeat (n) @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic rst_pulse_check(input string tag);
    @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    check({tag, "_pll_rst"},   int'(pll_rst),         1);
    check({tag, "_sys_rst"},   int'(sys_rst),         1);
    check({tag, "_ready"},     int'(ready),           0);
    check({tag, "_lock_fail"}, int'(lock_fail),       0);
    check({tag, "_loss"},      int'(lock_loss_count), 0);
    rst = 1'b0;
  endtask

  int pr, first, first2, len;

  initial begin
    // Clean lock: pll_locked rises just before edge 20 after release.
    pll_locked = 1'b0;
    reset_for(3);
    pr = 0; first = -1;
    for (int i = 1; i <= 40; i++) begin
      pll_locked = (i >= 20);
      @(negedge refclk);
      if (pll_rst) pr++;
      if (!sys_rst && first < 0) first = i;
    end
    check("s1_pll_rst_width", pr, 4);
    check("s1_release_edge", first, 33);
    check("s1_ready", int'(ready), 1);
    check("s1_loss", int'(lock_loss_count), 0);

    // Lock never arrives: two pulses, two timeouts, then FAIL.
    pll_locked = 1'b0;
    reset_for(2);
    pr = 0; first = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge refclk);
      if (pll_rst) pr++;
      if (lock_fail && first < 0) first = i;
    end
    check("s2_pll_rst_total", pr, 8);
    check("s2_fail_edge", first, 209);
    check("s2_lock_fail", int'(lock_fail), 1);
    check("s2_sys_rst", int'(sys_rst), 1);
    check("s2_pll_rst_low", int'(pll_rst), 0);
    rst_pulse_check("s2_rst_from_fail");

    // One-cycle dropout during qualification restarts it.
    pll_locked = 1'b0;
    reset_for(3);
    first = -1;
    for (int i = 1; i <= 50; i++) begin
      pll_locked = (i >= 20) && (i != 26);
      @(negedge refclk);
      if (!sys_rst && first < 0) first = i;
    end
    check("s3_release_edge", first, 40);

    // Repeated lock losses in RUN saturate the counter without touching the PLL.
    pr = 0;
    for (int k = 0; k < 300; k++) begin
      first = -1; first2 = -1;
      for (int j = 1; j <= 19; j++) begin
        pll_locked = (j > 3);
        @(negedge refclk);
        if (pll_rst) pr++;
        if (sys_rst && first < 0) first = j;
        if (!sys_rst && first >= 0 && first2 < 0) first2 = j;
      end
      if (k == 0) begin
        check("s4_sysrst_after_drop", first, 4);
        check("s4_rerun_edge", first2, 17);
        check("s4_loss_first", int'(lock_loss_count), 1);
      end
    end
    repeat (4) @(negedge refclk);
    check("s4_loss_sat", int'(lock_loss_count), 255);
    check("s4_no_pll_rst", pr, 0);
    check("s4_ready", int'(ready), 1);

    // Reset while running.
    rst_pulse_check("s5_rst_in_run");

`ifdef PLLSEQ_SOFT_RESET_EN
    // Soft restart in RUN keeps the loss count.
    pll_locked = 1'b1;
    repeat (25) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (20) @(negedge refclk);
    check("s6_ready_before", int'(ready), 1);
    soft_rst_req = 1'b1;
    @(negedge refclk);
    soft_rst_req = 1'b0;
    pr = 0;
    repeat (12) begin
      @(negedge refclk);
      if (pll_rst) pr++;
    end
    check("s6_pll_rst_width", pr, 4);
    check("s6_loss_kept", int'(lock_loss_count), 1);
`endif

    // Random lock patterns with occasional resets.
    for (int s = 0; s < 400; s++) begin
      pll_locked = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 25);
      if (!pll_locked && $urandom_range(0, 4) == 0) len = $urandom_range(100, 250);
      rst = ($urandom_range(0, 40) == 0);
`ifdef PLLSEQ_SOFT_RESET_EN
      soft_rst_req = ($urandom_range(0, 30) == 0);
`endif
      repeat (len) begin
        @(negedge refclk);
        rst = 1'b0;
`ifdef PLLSEQ_SOFT_RESET_EN
        soft_rst_req = 1'b0;
`endif
      end
    end

    repeat (2) @(negedge refclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
